// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment display blocks.
// Segment bit order is {a,b,c,d,e,f,g,dp}, active-high.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] SEL_NONE  = 4'b0000;
    localparam logic [3:0] SEL_LEFT  = 4'b1000;
    localparam logic [3:0] SEL_MIDL  = 4'b0100;
    localparam logic [3:0] SEL_MIDR  = 4'b0010;
    localparam logic [3:0] SEL_RIGHT = 4'b0001;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;

    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_H     = 8'h6E;
    localparam logic [7:0] SEG_L     = 8'h1C;
    localparam logic [7:0] SEG_P     = 8'hCE;
    localparam logic [7:0] SEG_U     = 8'h7C;

    // Digit 0 is the leftmost position on the board.
    function automatic logic [3:0] digit_select(input logic [1:0] digit);
        case (digit)
            2'd0:    digit_select = SEL_LEFT;
            2'd1:    digit_select = SEL_MIDL;
            2'd2:    digit_select = SEL_MIDR;
            default: digit_select = SEL_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// The count freezes while disabled and restarts from zero on clear.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic fastclk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

    always_ff @(posedge fastclk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scroll_display_sequencer.sv
// Scrolls a loaded message of segment patterns across the 4-digit display,
// multiplexing one digit per refresh slot and stepping the window per scroll tick.
module scroll_display_sequencer
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50_000,
    parameter int unsigned SCROLL_DIV  = 100_000_000,
    parameter int unsigned MSG_DEPTH   = 16
) (
    input  logic                       fastclk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [$clog2(MSG_DEPTH)-1:0] load_addr,
    input  logic [7:0]                 load_seg,
    input  logic [$clog2(MSG_DEPTH):0] msg_len,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       stop,
    output logic                       busy,
    output logic                       wrapped,
    output logic [3:0]                 select,
    output logic [7:0]                 hex_display
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_buf [MSG_DEPTH];
    logic [LW-1:0]   r_len;
    logic [AW-1:0]   r_pos;
    logic [1:0]      r_digit;
    logic [3:0]      r_select;
    logic [7:0]      r_hex;
    logic            r_wrapped;

    logic            w_len_ok;
    logic            w_start_go;
    logic            w_load_fire;
    logic            w_tick_clr;
    logic            w_refresh_tick;
    logic            w_scroll_tick;
    logic [LW-1:0]   w_idx;
    logic [7:0]      w_seg;

    assign load_ready  = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign wrapped     = r_wrapped;
    assign select      = r_select;
    assign hex_display = r_hex;

    assign w_len_ok    = (msg_len != '0) && (msg_len <= LW'(MSG_DEPTH));
    assign w_start_go  = start && w_len_ok && !stop;
    assign w_load_fire = load_valid && load_ready;
    assign w_tick_clr  = (r_state == ST_IDLE) || w_start_go || stop;

    tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
        .fastclk (fastclk),
        .reset   (reset),
        .i_en    (r_state != ST_IDLE),
        .i_clr   (w_tick_clr),
        .o_tick  (w_refresh_tick)
    );

    tick_gen #(.DIV(SCROLL_DIV)) u_scroll (
        .fastclk (fastclk),
        .reset   (reset),
        .i_en    (r_state == ST_RUN),
        .i_clr   (w_tick_clr),
        .o_tick  (w_scroll_tick)
    );

    always_ff @(posedge fastclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (stop)            w_state_nxt = ST_IDLE;
                else if (w_start_go) w_state_nxt = ST_RUN;
                else if (pause)      w_state_nxt = ST_HOLD;
                else                 w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Window index wraps by repeated subtraction: pos < len and digit <= 3,
    // so at most three subtractions cover even len=1.
    always_comb begin
        w_idx = LW'(r_pos) + LW'(r_digit);
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_idx >= r_len) w_idx = w_idx - r_len;
        end
        w_seg = '0;
        for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
            if (w_idx == LW'(i)) w_seg = r_buf[i];
        end
    end

    always_ff @(posedge fastclk) begin
        if (w_load_fire) r_buf[load_addr] <= load_seg;
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            r_len     <= LW'(1);
            r_pos     <= '0;
            r_digit   <= '0;
            r_select  <= SEL_NONE;
            r_hex     <= SEG_BLANK;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            if (w_state_nxt == ST_IDLE) begin
                r_pos    <= '0;
                r_digit  <= '0;
                r_select <= SEL_NONE;
                r_hex    <= SEG_BLANK;
            end else if (w_start_go) begin
                r_len   <= msg_len;
                r_pos   <= '0;
                r_digit <= '0;
            end else begin
                // The slot latched here uses the pre-scroll position.
                if (w_refresh_tick) begin
                    r_select <= digit_select(r_digit);
                    r_hex    <= w_seg;
                    r_digit  <= r_digit + 2'd1;
                end
                if (w_scroll_tick) begin
                    if (LW'(r_pos) == r_len - LW'(1)) begin
                        r_pos     <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_pos <= r_pos + AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scroll_display_sequencer.sv
// Directed and randomized checks of scroll_display_sequencer against a
// cycle-level behavioural model of the message window.
module tb_scroll_display_sequencer;

    localparam int RD = 4;
    localparam int SD = 64;

    logic       fastclk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_addr = '0;
    logic [7:0] load_seg = '0;
    logic [4:0] msg_len = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       wrapped;
    logic [3:0] select;
    logic [7:0] hex_display;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 scrolling, 2 held.
    int         m_mode = 0, m_len = 1, m_pos = 0, m_rc = 0, m_sc = 0, m_digit = 0;
    logic [3:0] m_sel = '0;
    logic [7:0] m_hex = '0;
    logic       m_wrap = 1'b0;
    logic [7:0] m_buf [16];

    always #5 fastclk = ~fastclk;

    scroll_display_sequencer #(
        .REFRESH_DIV (RD),
        .SCROLL_DIV  (SD),
        .MSG_DEPTH   (16)
    ) dut (
        .fastclk     (fastclk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_seg    (load_seg),
        .msg_len     (msg_len),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .busy        (busy),
        .wrapped     (wrapped),
        .select      (select),
        .hex_display (hex_display)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit start_ok, rt, stk;
        start_ok = start && (msg_len >= 1) && (msg_len <= 16) && !stop;
        m_wrap = 1'b0;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_digit = 0; m_rc = 0; m_sc = 0;
            m_sel = '0; m_hex = '0;
        end else begin
            if (load_valid && m_mode == 0) m_buf[load_addr] = load_seg;
            if (m_mode == 0) begin
                if (start_ok) begin
                    m_mode = 1; m_len = msg_len; m_pos = 0; m_digit = 0; m_rc = 0; m_sc = 0;
                end
            end else if (stop) begin
                m_mode = 0; m_pos = 0; m_digit = 0; m_rc = 0; m_sc = 0;
                m_sel = '0; m_hex = '0;
            end else if (start_ok) begin
                m_mode = 1; m_len = msg_len; m_pos = 0; m_digit = 0; m_rc = 0; m_sc = 0;
            end else begin
                rt = (m_rc == RD - 1);
                m_rc = rt ? 0 : m_rc + 1;
                stk = 0;
                if (m_mode == 1) begin
                    stk = (m_sc == SD - 1);
                    m_sc = stk ? 0 : m_sc + 1;
                end
                if (rt) begin
                    m_sel = 4'b1000 >> m_digit;
                    m_hex = m_buf[(m_pos + m_digit) % m_len];
                    m_digit = (m_digit + 1) % 4;
                end
                if (stk) begin
                    if (m_pos == m_len - 1) begin
                        m_pos = 0; m_wrap = 1'b1;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end
                m_mode = pause ? 2 : 1;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge fastclk);
        #1;
        chk("select", 32'(select), 32'(m_sel));
        chk("hex", 32'(hex_display), 32'(m_hex));
        chk("wrapped", 32'(wrapped), 32'(m_wrap));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("load_ready", 32'(load_ready), 32'(m_mode == 0));
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] s);
        load_valid = 1'b1; load_addr = a; load_seg = s;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] len);
        msg_len = len; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] pat [4];
        int wraps;
        int n, p;
        pat[0] = 8'hDA; pat[1] = 8'hFC; pat[2] = 8'h60; pat[3] = 8'hF6;
        for (int i = 0; i < 16; i++) m_buf[i] = '0;

        // Reset and idle
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (100) step();
        chk("idle_select", 32'(select), 32'h0);
        chk("idle_hex", 32'(hex_display), 32'h0);
        chk("idle_ready", 32'(load_ready), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);

        // Fill buffer, then the "2019" message in the first four entries
        for (int i = 0; i < 16; i++) load(4'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) load(4'(i), pat[i]);

        pulse_start(5'd4);
        for (n = 1; n <= 20; n++) begin
            repeat (4) step();
            p = (n <= 16) ? 0 : 1;
            chk("frame_select", 32'(select), 32'(4'b1000 >> ((n - 1) % 4)));
            chk("frame_hex", 32'(hex_display), 32'(pat[((n - 1) % 4 + p) % 4]));
        end
        stop = 1'b1; step(); stop = 1'b0;

        // Six-entry message: wrap cadence and the position-5 window
        pulse_start(5'd6);
        wraps = 0;
        for (int t = 1; t <= 6 * SD * 2; t++) begin
            step();
            if (wrapped) wraps++;
            if (t >= 324 && t <= 336 && (t % 4) == 0)
                chk("pos5_hex", 32'(hex_display), 32'(m_buf[(5 + (t - 324) / 4) % 6]));
        end
        chk("wrap_count", 32'(wraps), 32'd2);

        // Pause mid-scroll
        repeat (100) step();
        pause = 1'b1;
        repeat (200) step();
        chk("pause_busy", 32'(busy), 32'h1);
        pause = 1'b0;
        repeat (300) step();

        // Writes while scrolling are refused
        load_valid = 1'b1; load_addr = 4'd0; load_seg = ~m_buf[0];
        repeat (10) step();
        load_valid = 1'b0;
        repeat (50) step();

        // Stop and start together
        stop = 1'b1; start = 1'b1; msg_len = 5'd4;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stopstart_busy", 32'(busy), 32'h0);
        chk("stopstart_select", 32'(select), 32'h0);
        chk("stopstart_hex", 32'(hex_display), 32'h0);

        // Illegal lengths are ignored
        pulse_start(5'd0);
        chk("len0_busy", 32'(busy), 32'h0);
        pulse_start(5'd17);
        chk("len17_busy", 32'(busy), 32'h0);

        // Reset mid-run, then short message repeating within the window
        pulse_start(5'd5);
        repeat (150) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_hex", 32'(hex_display), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_wrapped", 32'(wrapped), 32'h0);
        pulse_start(5'd3);
        repeat (4) step();
        chk("restart_hex", 32'(hex_display), 32'(m_buf[0]));
        repeat (200) step();

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(15) == 0) pause = ~pause;
            start      = ($urandom_range(99) == 0);
            msg_len    = 5'($urandom_range(17));
            stop       = ($urandom_range(399) == 0);
            load_valid = ($urandom_range(3) == 0);
            load_addr  = 4'($urandom);
            load_seg   = 8'($urandom);
            step();
        end
        start = 1'b0; stop = 1'b0; load_valid = 1'b0; pause = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
